// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter with bus lock for the sim memory data port.
// Define MEM_ARB_FIXED_PRIO_EN to make m0 always win conflicts in the ARB state.
module mem_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_raddr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
    state_t state_q, state_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic prio_q, prio_d;
`endif
    logic [RD_LAT-1:0] tv_q, tv_d, ti_q, ti_d;
    logic arb0, any_gnt, sel_lock;
    logic [3:0] sel_wen;
    logic [31:0] sel_addr, sel_wdata;

    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        arb0 = m0_req;
`else
        arb0 = m0_req && (!m1_req || !prio_q);
`endif
        // gnt is gated by rst_n so nothing is accepted while reset is held
        m0_gnt = rst_n && (state_q == LOCK0 ? m0_req : (state_q == ARB && arb0));
        m1_gnt = rst_n && (state_q == LOCK1 ? m1_req : (state_q == ARB && m1_req && !arb0));
        any_gnt = m0_gnt || m1_gnt;
        sel_addr = m1_gnt ? m1_addr : m0_addr;
        sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
        sel_wen = m1_gnt ? m1_wen : m0_wen;
        sel_lock = m1_gnt ? m1_lock : m0_lock;
        mem_raddr = any_gnt ? sel_addr : '0;
        mem_waddr = any_gnt ? sel_addr : '0;
        mem_wdata = any_gnt ? sel_wdata : '0;
        mem_wen = any_gnt ? sel_wen : '0;
        state_d = state_q;
        if (any_gnt && state_q == ARB && sel_lock)
            state_d = m1_gnt ? LOCK1 : LOCK0;
        else if (any_gnt && state_q != ARB && !sel_lock)
            state_d = ARB;
`ifndef MEM_ARB_FIXED_PRIO_EN
        prio_d = (state_q == ARB && any_gnt) ? m0_gnt : prio_q;
`endif
        tv_d = {tv_q[RD_LAT-2:0], any_gnt && sel_wen == 4'd0};
        ti_d = {ti_q[RD_LAT-2:0], m1_gnt};
        m0_rvalid = tv_q[RD_LAT-1] && !ti_q[RD_LAT-1];
        m1_rvalid = tv_q[RD_LAT-1] && ti_q[RD_LAT-1];
        m0_rdata = m0_rvalid ? mem_rdata : '0;
        m1_rdata = m1_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
`ifndef MEM_ARB_FIXED_PRIO_EN
            prio_q <= 1'b0;
`endif
            tv_q <= '0;
            ti_q <= '0;
        end else begin
            state_q <= state_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            prio_q <= prio_d;
`endif
            tv_q <= tv_d;
            ti_q <= ti_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random stimulus checked every cycle against a transaction-level model.
module tb_mem_arbiter;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0, rst_n;
    logic m0_req, m0_lock, m0_gnt, m0_rvalid, m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [3:0] m0_wen, m1_wen, mem_wen;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata, rd1;
    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    int n_chk = 0, n_fail = 0, cyc = 0;

    mem_arbiter #(.RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory device: writes land at the closing posedge, reads return two cycles after the grant.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wen[b]) mem[mem_waddr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        rd1 <= mem[mem_raddr[9:2]];
        mem_rdata <= rd1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: lock owner, round-robin winner, shadow memory and a queue of due returns.
    typedef struct { int due; int id; logic [31:0] data; } ret_t;
    ret_t rq[$];
    int lock_own = -1, pri = 0, w, ev;
    bit e0, e1;
    logic lk;
    logic [3:0] wn;
    logic [31:0] a, d, edata;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            lock_own = -1;
            pri = 0;
            rq.delete();
            chk("rst_m0_gnt", m0_gnt, 0);
            chk("rst_m1_gnt", m1_gnt, 0);
            chk("rst_m0_rvalid", m0_rvalid, 0);
            chk("rst_m1_rvalid", m1_rvalid, 0);
            chk("rst_mem_wen", mem_wen, 0);
        end else begin
            if (lock_own == 0) begin e0 = m0_req; e1 = 0; end
            else if (lock_own == 1) begin e0 = 0; e1 = m1_req; end
            else if (m0_req && m1_req) begin e0 = FIXED || pri == 0; e1 = !e0; end
            else begin e0 = m0_req; e1 = m1_req; end
            chk("m0_gnt", m0_gnt, e0);
            chk("m1_gnt", m1_gnt, e1);
            w = e0 ? 0 : (e1 ? 1 : -1);
            a = w == 1 ? m1_addr : m0_addr;
            d = w == 1 ? m1_wdata : m0_wdata;
            wn = w == 1 ? m1_wen : m0_wen;
            lk = w == 1 ? m1_lock : m0_lock;
            if (w < 0) begin
                chk("idle_raddr", mem_raddr, 0);
                chk("idle_wen", mem_wen, 0);
                chk("idle_waddr", mem_waddr, 0);
                chk("idle_wdata", mem_wdata, 0);
            end else begin
                chk("mem_raddr", mem_raddr, a);
                chk("mem_wen", mem_wen, wn);
                if (wn != 0) begin
                    chk("mem_waddr", mem_waddr, a);
                    chk("mem_wdata", mem_wdata, d);
                end
            end
            ev = -1;
            edata = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ev = rq[0].id;
                edata = rq[0].data;
                void'(rq.pop_front());
            end
            chk("m0_rvalid", m0_rvalid, ev == 0);
            chk("m0_rdata", m0_rdata, ev == 0 ? edata : 0);
            chk("m1_rvalid", m1_rvalid, ev == 1);
            chk("m1_rdata", m1_rdata, ev == 1 ? edata : 0);
            if (w >= 0) begin
                if (wn == 0) rq.push_back('{cyc + 2, w, shadow[a[9:2]]});
                for (int b = 0; b < 4; b++)
                    if (wn[b]) shadow[a[9:2]][8*b +: 8] = d[8*b +: 8];
                if (lock_own < 0) begin
                    pri = 1 - w;
                    if (lk) lock_own = w;
                end else if (!lk) lock_own = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(logic r, logic l, logic [3:0] wen, logic [31:0] ad, logic [31:0] wd);
        m0_req = r; m0_lock = l; m0_wen = wen; m0_addr = ad; m0_wdata = wd;
    endtask

    task automatic set1(logic r, logic l, logic [3:0] wen, logic [31:0] ad, logic [31:0] wd);
        m1_req = r; m1_lock = l; m1_wen = wen; m1_addr = ad; m1_wdata = wd;
    endtask

    task automatic do_reset();
        tick();
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic rnd(output logic r, output logic l, output logic [3:0] wen, output logic [31:0] ad, output logic [31:0] wd);
        r = $urandom_range(0, 3) != 0;
        l = $urandom_range(0, 5) == 0;
        wen = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        ad = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        wd = $urandom;
    endtask

    logic g0p = 0, g1p = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA500_0000 | i;
            shadow[i] = 32'hA500_0000 | i;
        end
        mem[64] = 32'hDEAD_BEEF;
        shadow[64] = 32'hDEAD_BEEF;
        rst_n = 0;
        set0(1, 0, 0, 32'h100, 0);
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_rst_gated", m0_gnt, 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("lit_t1_gnt", m0_gnt, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_t1_rv_early", m0_rvalid, 0);
        tick();
        @(negedge clk);
        chk("lit_t1_rv", m0_rvalid, 1);
        chk("lit_t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("lit_t1_m1rv", m1_rvalid, 0);

        do_reset();
        set0(1, 0, 0, 0, 0);
        set1(1, 0, 0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_t2_g0", m0_gnt, FIXED || i % 2 == 0);
            chk("lit_t2_g1", m1_gnt, !FIXED && i % 2 == 1);
            tick();
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();

        set1(1, 0, 4'hF, 32'h40, 32'h1234_5678);
        @(negedge clk);
        chk("lit_t3_wgnt", m1_gnt, 1);
        tick();
        set1(1, 0, 0, 32'h40, 0);
        @(negedge clk);
        tick();
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("lit_t3_rv", m1_rvalid, 1);
        chk("lit_t3_full", m1_rdata, 32'h1234_5678);
        tick();
        set1(1, 0, 4'h2, 32'h40, 32'h0000_AB00);
        @(negedge clk);
        tick();
        set1(1, 0, 0, 32'h40, 0);
        @(negedge clk);
        tick();
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("lit_t3_byte", m1_rdata, 32'h1234_AB78);

        do_reset();
        set1(1, 0, 0, 32'h8, 0);
        set0(1, 1, 0, 32'h80, 0);
        @(negedge clk);
        chk("lit_t4_g0_lock", m0_gnt, 1);
        chk("lit_t4_g1_a", m1_gnt, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_t4_g1_held", m1_gnt, 0);
        tick();
        set0(1, 0, 4'hF, 32'h80, 32'hCAFE_F00D);
        @(negedge clk);
        chk("lit_t4_g0_unlock", m0_gnt, 1);
        chk("lit_t4_g1_b", m1_gnt, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_t4_g1_free", m1_gnt, 1);
        tick();
        set1(0, 0, 0, 0, 0);
        repeat (2) tick();

        set0(1, 0, 0, 32'h0, 0);
        @(negedge clk);
        tick();
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 0, 32'h4, 0);
        @(negedge clk);
        tick();
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 0, 32'h8, 0);
        @(negedge clk);
        chk("lit_t5_rv0a", m0_rvalid, 1);
        chk("lit_t5_d0a", m0_rdata, 32'hA500_0000);
        tick();
        set0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lit_t5_rv1", m1_rvalid, 1);
        chk("lit_t5_d1", m1_rdata, 32'hA500_0001);
        chk("lit_t5_rv0_off", m0_rvalid, 0);
        tick();
        @(negedge clk);
        chk("lit_t5_rv0b", m0_rvalid, 1);
        chk("lit_t5_d0b", m0_rdata, 32'hA500_0002);

        tick();
        set0(1, 0, 0, 32'h100, 0);
        @(negedge clk);
        chk("lit_t6_gnt", m0_gnt, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_t6_no_rv0", m0_rvalid, 0);
            chk("lit_t6_no_rv1", m1_rvalid, 0);
            tick();
        end
        set0(1, 0, 0, 32'h0, 0);
        set1(1, 0, 0, 32'h4, 0);
        @(negedge clk);
        chk("lit_t6_prio", m0_gnt, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        set1(1, 1, 0, 32'h4, 0);
        @(negedge clk);
        chk("lit_t6_m1_lock", m1_gnt, 1);
        tick();
        set1(0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        set0(1, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("lit_t6_unlocked", m0_gnt, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        repeat (3) tick();

        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 299) != 0;
            if (!m0_req || g0p) rnd(m0_req, m0_lock, m0_wen, m0_addr, m0_wdata);
            if (!m1_req || g1p) rnd(m1_req, m1_lock, m1_wen, m1_addr, m1_wdata);
            @(negedge clk);
            g0p = m0_gnt;
            g1p = m1_gnt;
            tick();
        end
        rst_n = 1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
